// File: rtl/dcache_line_ctrl_pkg.sv
// Shared types and defaults for the direct-mapped write-back data cache.
package dcache_line_ctrl_pkg;

  localparam int unsigned DC_LINES_DEF      = 64;
  localparam int unsigned DC_LINE_WORDS_DEF = 4;

  typedef enum logic [1:0] {
    DC_IDLE = 2'd0,
    DC_WB   = 2'd1,
    DC_FILL = 2'd2,
    DC_DONE = 2'd3
  } dc_state_e;

  function automatic logic [31:0] dc_sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Per-line valid/dirty/tag/data storage: one combinational read port, one write port.
module dcache_line_store
  import dcache_line_ctrl_pkg::*;
#(
  parameter int unsigned LINES      = DC_LINES_DEF,
  parameter int unsigned LINE_WORDS = DC_LINE_WORDS_DEF,
  parameter int unsigned IDX_W      = $clog2(LINES),
  parameter int unsigned OFF_W      = $clog2(LINE_WORDS),
  parameter int unsigned TAG_W      = 30 - IDX_W - OFF_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [OFF_W-1:0] rd_off_i,
  output logic             rd_valid_o,
  output logic             rd_dirty_o,
  output logic [TAG_W-1:0] rd_tag_o,
  output logic [31:0]      rd_word_o,
  input  logic             wr_data_en_i,
  input  logic [OFF_W-1:0] wr_off_i,
  input  logic [31:0]      wr_word_i,
  input  logic             wr_meta_en_i,
  input  logic             wr_valid_i,
  input  logic             wr_dirty_i,
  input  logic [TAG_W-1:0] wr_tag_i
);

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES][LINE_WORDS];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_meta_en_i) begin
      valid_q[idx_i] <= wr_valid_i;
      dirty_q[idx_i] <= wr_dirty_i;
    end
  end

  // Tag and data arrays carry no reset; valid alone qualifies their contents.
  always_ff @(posedge clk) begin
    if (!rst && wr_meta_en_i) tag_q[idx_i] <= wr_tag_i;
    if (!rst && wr_data_en_i) data_q[idx_i][wr_off_i] <= wr_word_i;
  end

  assign rd_valid_o = valid_q[idx_i];
  assign rd_dirty_o = dirty_q[idx_i];
  assign rd_tag_o   = tag_q[idx_i];
  assign rd_word_o  = data_q[idx_i][rd_off_i];

endmodule

// File: rtl/dcache_line_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller.
// Define DCACHE_STAT_EN to add saturating hit/miss counters (stat_hits, stat_misses).
module dcache_line_ctrl
  import dcache_line_ctrl_pkg::*;
#(
  parameter int unsigned LINES      = DC_LINES_DEF,
  parameter int unsigned LINE_WORDS = DC_LINE_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ren,
  input  logic        cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_din,
  output logic [31:0] cpu_dout,
  output logic        cpu_stall,
  output logic        ram_req,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_dout,
  input  logic [31:0] ram_din,
`ifdef DCACHE_STAT_EN
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses,
`endif
  input  logic        ram_ack
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 30 - IDX_W - OFF_W;

  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             unused_addr_lsb;

  assign req_off         = cpu_addr[OFF_W+1:2];
  assign req_idx         = cpu_addr[OFF_W+2 +: IDX_W];
  assign req_tag         = cpu_addr[31 -: TAG_W];
  assign unused_addr_lsb = ^cpu_addr[1:0];

  dc_state_e        state_q;
  logic [OFF_W-1:0] word_cnt_q;
  logic [OFF_W-1:0] word_cnt_d;
  logic             ram_req_q;
  logic             ram_we_q;
  logic [31:0]      ram_addr_q;

  logic             rd_valid, rd_dirty;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_word;
  logic [OFF_W-1:0] rd_off;
  logic             wr_data_en, wr_meta_en, wr_dirty;
  logic [OFF_W-1:0] wr_off;
  logic [31:0]      wr_word;
  logic [TAG_W-1:0] wr_tag;

  logic req_any, hit, last_word, hit_wr;

  assign req_any    = cpu_ren || cpu_wen;
  assign hit        = rd_valid && (rd_tag == req_tag);
  assign last_word  = (word_cnt_q == OFF_W'(LINE_WORDS - 1));
  assign word_cnt_d = word_cnt_q + OFF_W'(1);
  assign hit_wr     = (state_q == DC_IDLE) && cpu_wen && hit;

  always_comb begin
    rd_off     = (state_q == DC_WB) ? word_cnt_q : req_off;
    wr_data_en = hit_wr || ((state_q == DC_FILL) && ram_ack);
    wr_off     = (state_q == DC_FILL) ? word_cnt_q : req_off;
    wr_word    = (state_q == DC_FILL) ? ram_din : cpu_din;
    wr_meta_en = hit_wr || (((state_q == DC_WB) || (state_q == DC_FILL)) && ram_ack && last_word);
    wr_dirty   = (state_q == DC_IDLE);
    wr_tag     = (state_q == DC_FILL) ? req_tag : rd_tag;
  end

  dcache_line_store #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_store (
    .clk          (clk),
    .rst          (rst),
    .idx_i        (req_idx),
    .rd_off_i     (rd_off),
    .rd_valid_o   (rd_valid),
    .rd_dirty_o   (rd_dirty),
    .rd_tag_o     (rd_tag),
    .rd_word_o    (rd_word),
    .wr_data_en_i (wr_data_en),
    .wr_off_i     (wr_off),
    .wr_word_i    (wr_word),
    .wr_meta_en_i (wr_meta_en),
    .wr_valid_i   (1'b1),
    .wr_dirty_i   (wr_dirty),
    .wr_tag_i     (wr_tag)
  );

  // ram_addr is registered, so each transition loads the address of the next word to present.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DC_IDLE;
      word_cnt_q <= '0;
      ram_req_q  <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
    end else begin
      unique case (state_q)
        DC_IDLE: begin
          if (req_any && !hit) begin
            word_cnt_q <= '0;
            ram_req_q  <= 1'b1;
            if (rd_valid && rd_dirty) begin
              state_q    <= DC_WB;
              ram_we_q   <= 1'b1;
              ram_addr_q <= {rd_tag, req_idx, {OFF_W{1'b0}}, 2'b00};
            end else begin
              state_q    <= DC_FILL;
              ram_we_q   <= 1'b0;
              ram_addr_q <= {req_tag, req_idx, {OFF_W{1'b0}}, 2'b00};
            end
          end
        end
        DC_WB: begin
          if (ram_ack) begin
            word_cnt_q <= word_cnt_d;
            if (last_word) begin
              state_q    <= DC_FILL;
              ram_we_q   <= 1'b0;
              ram_addr_q <= {req_tag, req_idx, {OFF_W{1'b0}}, 2'b00};
            end else begin
              ram_addr_q <= {rd_tag, req_idx, word_cnt_d, 2'b00};
            end
          end
        end
        DC_FILL: begin
          if (ram_ack) begin
            word_cnt_q <= word_cnt_d;
            if (last_word) begin
              state_q   <= DC_DONE;
              ram_req_q <= 1'b0;
            end else begin
              ram_addr_q <= {req_tag, req_idx, word_cnt_d, 2'b00};
            end
          end
        end
        DC_DONE: state_q <= DC_IDLE;
      endcase
    end
  end

  assign cpu_stall = (state_q != DC_IDLE) || (req_any && !hit);
  assign cpu_dout  = hit ? rd_word : '0;
  assign ram_req   = ram_req_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_dout  = (state_q == DC_WB) ? rd_word : '0;

`ifdef DCACHE_STAT_EN
  logic [31:0] hits_q, misses_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else if ((state_q == DC_IDLE) && req_any) begin
      if (hit) hits_q   <= dc_sat_inc(hits_q);
      else     misses_q <= dc_sat_inc(misses_q);
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`endif

endmodule
